alu_exec_seq: RTL and testbench
===============================

# alu_exec_seq

Multi-cycle execute sequencer for the 16-bit ALU. Accepts one decoded instruction at a time over a valid/ready handshake, reads operands from the register file, drives the ALU, writes the result back and maintains the five-bit processor status register (PSR). It sits between the decoder and the ALU/register-file pair and is the only master of both.

## Interface
- `REG_AW`, default 4: register address width (16 registers).
- `IMM_W`, default 8: immediate field width; extended to 16 bits.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instr_valid` in 1: an instruction is presented.
- `instr_ready` out 1: the sequencer is in IDLE and will accept.
- `instr_opcode` in 8: ALU opcode, using the shared opcode constants.
- `instr_rdest` in REG_AW: destination register, which is also operand A.
- `instr_rsrc` in REG_AW: operand B register; ignored for immediate opcodes.
- `instr_imm` in IMM_W: immediate value.
- `rf_raddr_a`, `rf_raddr_b` out REG_AW: register-file read addresses.
- `rf_rdata_a`, `rf_rdata_b` in 16: read data, valid one cycle after the address.
- `rf_we` out 1, `rf_waddr` out REG_AW, `rf_wdata` out 16: write-back port.
- `alu_a`, `alu_b` out 16, `alu_opcode` out 8, `alu_carry_in` out 1: ALU inputs.
- `alu_c` in 16; `alu_carry`, `alu_flag`, `alu_low`, `alu_negative`, `alu_zero` in 1: ALU outputs.
- `psr` out 5: status bits {C,F,L,N,Z}.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse when an instruction with an unrecognised opcode retires.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. There is no other path, except that `reset` forces IDLE from any state.
- **IDLE**
  - `instr_ready`=1.
  - When `instr_valid`=1, latch opcode, rdest, rsrc and imm, then go to READ.
- **READ**
  - Drive `rf_raddr_a`=rdest and `rf_raddr_b`=rsrc.
- **EXEC**
  - `alu_a`=`rf_rdata_a`.
  - `alu_b` is `rf_rdata_b` for register opcodes, or the extended imm for immediate opcodes: ADDI, ADDUI, ADDCUI, SUBI, CMPI, LSHI, RSHI.
  - `alu_carry_in`=`psr`[C].
  - At the end of the cycle, register `alu_c` into the result register and the five ALU flags into the staged flags.
- **WB**
  - `rf_we`=1 with `rf_waddr`=rdest and `rf_wdata`=result, except for CMP, CMPI, TEST, NOP and unrecognised opcodes, which do not write.
  - PSR takes the staged flags, except for NOP and unrecognised opcodes, which leave PSR unchanged.
  - `done`=1.
  - `illegal`=1 if the opcode is unrecognised.
- Outside their driving state:
  - `alu_*` and `rf_raddr_*` hold 0 in every other state, with `alu_opcode`=NOP.
  - `rf_we` is 0 outside WB.
- `instr_valid` is ignored while not in IDLE. The decoder holds the instruction until it sees `instr_valid`&&`instr_ready`.
- Write-back to register R followed by an instruction that reads R: the read occurs at least one cycle after WB, so the register file returns the new value. No forwarding is needed.
- Arithmetic is entirely inside the ALU. The sequencer performs no width changes except immediate extension.

## Timing
- Reset values:
  - state=IDLE
  - `psr`=5'b00000
  - `instr_ready`=1
  - `rf_we`, `done` and `illegal` = 0
  - all address and data outputs = 0
  - `alu_opcode`=NOP
- Accept at cycle N. READ is N+1, EXEC is N+2, WB is N+3. `done` is high in N+3, and `instr_ready` returns high in N+4.
- Throughput is one instruction per 4 cycles. Back-to-back valid gives accepts at N, N+4, N+8, ...
- `psr` changes on the clock edge that ends WB, so it is visible from N+4. ADDCU(I) in the next instruction sees the new C.
- Reset asserted in any state:
  - the in-flight instruction is discarded;
  - no write occurs in that cycle;
  - PSR is cleared;
  - `instr_ready`=1 in the cycle after reset deasserts.

## Configuration
- `ALU_EXEC_SEQ_IMM_SEXT_EN`
  - **Defined:** ADDI, SUBI and CMPI sign-extend imm from bit IMM_W-1. ADDUI, ADDCUI, LSHI and RSHI zero-extend.
  - **Undefined:** all immediate opcodes zero-extend.

## Structure
- Shared package holds:
  - opcode constants;
  - the PSR bit-index constants C=4, F=3, L=2, N=1, Z=0;
  - the FSM state enum;
  - the immediate-opcode and no-writeback opcode classification functions.
- One sub-module, `imm_extend`: imm plus a sign-select input in, 16-bit value out.
- FSM, latches and PSR stay in the top-level module.

## Test plan
- ADD, r1=0x0003, r2=0x0004 → EXEC asserts `alu_a`=0x0003, `alu_b`=0x0004; r1 becomes 0x0007 at WB (N+3); `psr`=00000; `done` at N+3.
- ADDU, r1=0xFFFF, r2=0x0001 → r1=0x0000 and `psr`[C]=1, `psr`[Z]=1. A following ADDCU with r3=r4=0 gives r3=0x0001.
- CMPI, r5=0x0002, imm=0xFF:
  - with `ALU_EXEC_SEQ_IMM_SEXT_EN` → `alu_b`=0xFFFF, N=0, L=1;
  - without → `alu_b`=0x00FF;
  - in both cases `rf_we` stays 0.
- Two back-to-back instructions with `instr_valid` held high → accepts exactly 4 cycles apart; `instr_ready` is low for 3 cycles after each accept.
- Reset asserted during EXEC of ADD → no write to rdest, `psr`=0, `instr_ready`=1 after release.
- Unrecognised opcode 0xEE → no write, PSR unchanged, `done` and `illegal` both pulse at N+3.

Source files
------------

// File: rtl/alu_exec_seq_pkg.sv
// Shared opcode constants, PSR bit indices, FSM state type and opcode classifiers
// for the execute sequencer.
package alu_exec_seq_pkg;

  localparam logic [7:0] OpNop    = 8'h00;
  localparam logic [7:0] OpAdd    = 8'h01;
  localparam logic [7:0] OpAddi   = 8'h02;
  localparam logic [7:0] OpAddu   = 8'h03;
  localparam logic [7:0] OpAddui  = 8'h04;
  localparam logic [7:0] OpAddcu  = 8'h05;
  localparam logic [7:0] OpAddcui = 8'h06;
  localparam logic [7:0] OpSub    = 8'h07;
  localparam logic [7:0] OpSubi   = 8'h08;
  localparam logic [7:0] OpCmp    = 8'h09;
  localparam logic [7:0] OpCmpi   = 8'h0A;
  localparam logic [7:0] OpAnd    = 8'h0B;
  localparam logic [7:0] OpOr     = 8'h0C;
  localparam logic [7:0] OpXor    = 8'h0D;
  localparam logic [7:0] OpNot    = 8'h0E;
  localparam logic [7:0] OpLsh    = 8'h0F;
  localparam logic [7:0] OpLshi   = 8'h10;
  localparam logic [7:0] OpRsh    = 8'h11;
  localparam logic [7:0] OpRshi   = 8'h12;
  localparam logic [7:0] OpTest   = 8'h13;

  localparam int unsigned PsrC = 4;
  localparam int unsigned PsrF = 3;
  localparam int unsigned PsrL = 2;
  localparam int unsigned PsrN = 1;
  localparam int unsigned PsrZ = 0;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return op inside {OpNop, OpAdd, OpAddi, OpAddu, OpAddui, OpAddcu, OpAddcui, OpSub, OpSubi,
                      OpCmp, OpCmpi, OpAnd, OpOr, OpXor, OpNot, OpLsh, OpLshi, OpRsh, OpRshi,
                      OpTest};
  endfunction

  function automatic logic is_imm_op(input logic [7:0] op);
    return op inside {OpAddi, OpAddui, OpAddcui, OpSubi, OpCmpi, OpLshi, OpRshi};
  endfunction

  // Unrecognised opcodes are treated as no-writeback as well.
  function automatic logic is_no_wb_op(input logic [7:0] op);
    return (op inside {OpCmp, OpCmpi, OpTest, OpNop}) || !is_legal_op(op);
  endfunction

  function automatic logic is_sext_op(input logic [7:0] op);
    return op inside {OpAddi, OpSubi, OpCmpi};
  endfunction

endpackage

// File: rtl/alu_exec_seq_imm_extend.sv
// Extends an IMM_W-bit immediate to 16 bits, sign- or zero-extending on i_sext.
module imm_extend #(
  parameter int unsigned IMM_W = 8
) (
  input  logic [IMM_W-1:0] i_imm,
  input  logic             i_sext,
  output logic [15:0]      o_value
);

  logic w_fill;

  assign w_fill  = i_sext & i_imm[IMM_W-1];
  assign o_value = {{(16 - IMM_W){w_fill}}, i_imm};

endmodule

// File: rtl/alu_exec_seq.sv
// Four-state execute sequencer: IDLE -> READ -> EXEC -> WB, owning PSR.
// ALU_EXEC_SEQ_IMM_SEXT_EN selects sign extension for ADDI/SUBI/CMPI immediates.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_opcode,
  input  logic [REG_AW-1:0] instr_rdest,
  input  logic [REG_AW-1:0] instr_rsrc,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [15:0]       rf_rdata_a,
  input  logic [15:0]       rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_carry_in,
  input  logic [15:0]       alu_c,
  input  logic              alu_carry,
  input  logic              alu_flag,
  input  logic              alu_low,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic [4:0]        psr,
  output logic              done,
  output logic              illegal
);

  state_e            r_state, w_state_d;
  logic [7:0]        r_opcode;
  logic [REG_AW-1:0] r_rdest, r_rsrc;
  logic [IMM_W-1:0]  r_imm;
  logic [15:0]       r_result;
  logic [4:0]        r_flags, r_psr;
  logic              w_sext;
  logic [15:0]       w_imm_ext;
  logic              w_legal;

`ifdef ALU_EXEC_SEQ_IMM_SEXT_EN
  assign w_sext = is_sext_op(r_opcode);
`else
  assign w_sext = 1'b0;
`endif

  assign w_legal = is_legal_op(r_opcode);

  imm_extend #(
    .IMM_W(IMM_W)
  ) u_imm_extend (
    .i_imm  (r_imm),
    .i_sext (w_sext),
    .o_value(w_imm_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_opcode <= OpNop;
      r_rdest  <= '0;
      r_rsrc   <= '0;
      r_imm    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_psr    <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && instr_valid) begin
        r_opcode <= instr_opcode;
        r_rdest  <= instr_rdest;
        r_rsrc   <= instr_rsrc;
        r_imm    <= instr_imm;
      end
      if (r_state == StExec) begin
        r_result <= alu_c;
        r_flags  <= {alu_carry, alu_flag, alu_low, alu_negative, alu_zero};
      end
      // NOP and unrecognised opcodes retire without touching PSR.
      if (r_state == StWb && w_legal && r_opcode != OpNop) begin
        r_psr <= r_flags;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    instr_ready  = 1'b0;
    rf_raddr_a   = '0;
    rf_raddr_b   = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_opcode   = OpNop;
    alu_carry_in = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    unique case (r_state)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) w_state_d = StRead;
      end
      StRead: begin
        rf_raddr_a = r_rdest;
        rf_raddr_b = r_rsrc;
        w_state_d  = StExec;
      end
      StExec: begin
        alu_a        = rf_rdata_a;
        alu_b        = is_imm_op(r_opcode) ? w_imm_ext : rf_rdata_b;
        alu_opcode   = r_opcode;
        alu_carry_in = r_psr[PsrC];
        w_state_d    = StWb;
      end
      StWb: begin
        rf_we     = !is_no_wb_op(r_opcode);
        rf_waddr  = r_rdest;
        rf_wdata  = r_result;
        done      = 1'b1;
        illegal   = !w_legal;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign psr = r_psr;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural register file and ALU.
module tb_alu_exec_seq;
  import alu_exec_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [3:0]  instr_rdest, instr_rsrc;
  logic [7:0]  instr_imm;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic        alu_carry, alu_flag, alu_low, alu_negative, alu_zero;
  logic [4:0]  psr;
  logic        done, illegal;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf [16];
  logic        tb_load;

  always #5 clk = ~clk;

  alu_exec_seq #(
    .REG_AW(4),
    .IMM_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_opcode(instr_opcode),
    .instr_rdest (instr_rdest),
    .instr_rsrc  (instr_rsrc),
    .instr_imm   (instr_imm),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_carry_in(alu_carry_in),
    .alu_c       (alu_c),
    .alu_carry   (alu_carry),
    .alu_flag    (alu_flag),
    .alu_low     (alu_low),
    .alu_negative(alu_negative),
    .alu_zero    (alu_zero),
    .psr         (psr),
    .done        (done),
    .illegal     (illegal)
  );

  // Register file with one-cycle read latency; preload sets the initial contents.
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
      rf[1]  <= 16'h0003;
      rf[2]  <= 16'h0004;
      rf[5]  <= 16'h0002;
      rf[8]  <= 16'h0005;
      rf[9]  <= 16'h0006;
      rf[10] <= 16'hFFFF;
      rf[11] <= 16'h0001;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
  end

  // Behavioural ALU: C carry-out, F signed overflow, L/N unsigned/signed less, Z zero.
  logic [16:0] s;
  always_comb begin
    s            = '0;
    alu_carry    = 1'b0;
    alu_flag     = 1'b0;
    alu_low      = 1'b0;
    alu_negative = 1'b0;
    case (alu_opcode)
      OpAdd, OpAddi: begin
        s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_flag = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
      end
      OpAddu, OpAddui: begin
        s         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = s[16];
      end
      OpAddcu, OpAddcui: begin
        s         = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_carry_in};
        alu_carry = s[16];
      end
      OpSub, OpSubi: s = {1'b0, alu_a - alu_b};
      OpCmp, OpCmpi: begin
        s            = {1'b0, alu_a - alu_b};
        alu_low      = alu_a < alu_b;
        alu_negative = $signed(alu_a) < $signed(alu_b);
      end
      OpAnd, OpTest: s = {1'b0, alu_a & alu_b};
      OpOr:          s = {1'b0, alu_a | alu_b};
      OpXor:         s = {1'b0, alu_a ^ alu_b};
      default:       s = '0;
    endcase
    alu_c    = s[15:0];
    alu_zero = (s[15:0] == 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) break;
      @(negedge clk);
    end
    check("ready_wait", {31'b0, instr_ready}, 32'd1);
  endtask

  // Issue one instruction from a negedge and check READ, EXEC, WB and the following IDLE.
  task automatic run_instr(input string name, input logic [7:0] op, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [7:0] imm,
                           input logic [15:0] exp_a, input logic [15:0] exp_b,
                           input logic exp_cin, input logic exp_we,
                           input logic [15:0] exp_wdata, input logic exp_ill,
                           input logic [4:0] exp_psr);
    wait_ready();
    instr_opcode = op;
    instr_rdest  = rd;
    instr_rsrc   = rs;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check({name, "_raddr_a"}, {28'b0, rf_raddr_a}, {28'b0, rd});
    check({name, "_raddr_b"}, {28'b0, rf_raddr_b}, {28'b0, rs});
    check({name, "_ready_rd"}, {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    check({name, "_alu_a"}, {16'b0, alu_a}, {16'b0, exp_a});
    check({name, "_alu_b"}, {16'b0, alu_b}, {16'b0, exp_b});
    check({name, "_alu_op"}, {24'b0, alu_opcode}, {24'b0, op});
    check({name, "_cin"}, {31'b0, alu_carry_in}, {31'b0, exp_cin});
    check({name, "_we_ex"}, {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    check({name, "_we"}, {31'b0, rf_we}, {31'b0, exp_we});
    if (exp_we) begin
      check({name, "_waddr"}, {28'b0, rf_waddr}, {28'b0, rd});
      check({name, "_wdata"}, {16'b0, rf_wdata}, {16'b0, exp_wdata});
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    @(negedge clk);
    check({name, "_psr"}, {27'b0, psr}, {27'b0, exp_psr});
    check({name, "_ready"}, {31'b0, instr_ready}, 32'd1);
    check({name, "_done_off"}, {31'b0, done}, 32'd0);
    check({name, "_op_idle"}, {24'b0, alu_opcode}, {24'b0, OpNop});
  endtask

  int acc[$];
  int low_cnt;
  int gap;

  initial begin
    reset        = 1'b1;
    tb_load      = 1'b1;
    instr_valid  = 1'b0;
    instr_opcode = 8'h00;
    instr_rdest  = 4'h0;
    instr_rsrc   = 4'h0;
    instr_imm    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    tb_load = 1'b0;
    @(negedge clk);
    check("rst_psr", {27'b0, psr}, 32'd0);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_we", {31'b0, rf_we}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_op", {24'b0, alu_opcode}, {24'b0, OpNop});
    check("rst_raddr", {24'b0, rf_raddr_a, rf_raddr_b}, 32'd0);
    check("rst_alu", {alu_a, alu_b}, 32'd0);

    run_instr("add", OpAdd, 4'd1, 4'd2, 8'h00, 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007,
              1'b0, 5'b00000);
    check("add_r1", {16'b0, rf[1]}, 32'h0007);

    run_instr("addu", OpAddu, 4'd10, 4'd11, 8'h00, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000,
              1'b0, 5'b10001);
    check("addu_r10", {16'b0, rf[10]}, 32'h0000);

    run_instr("addcu", OpAddcu, 4'd3, 4'd4, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001,
              1'b0, 5'b00000);
    check("addcu_r3", {16'b0, rf[3]}, 32'h0001);

`ifdef ALU_EXEC_SEQ_IMM_SEXT_EN
    run_instr("cmpi", OpCmpi, 4'd5, 4'd0, 8'hFF, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 16'h0000,
              1'b0, 5'b00100);
    run_instr("illegal", 8'hEE, 4'd5, 4'd2, 8'h00, 16'h0002, 16'h0004, 1'b0, 1'b0, 16'h0000,
              1'b1, 5'b00100);
`else
    run_instr("cmpi", OpCmpi, 4'd5, 4'd0, 8'hFF, 16'h0002, 16'h00FF, 1'b0, 1'b0, 16'h0000,
              1'b0, 5'b00110);
    run_instr("illegal", 8'hEE, 4'd5, 4'd2, 8'h00, 16'h0002, 16'h0004, 1'b0, 1'b0, 16'h0000,
              1'b1, 5'b00110);
`endif
    check("cmpi_r5", {16'b0, rf[5]}, 32'h0002);

    // Back-to-back: valid held high across two accepts.
    wait_ready();
    instr_opcode = OpAdd;
    instr_rdest  = 4'd6;
    instr_rsrc   = 4'd7;
    instr_valid  = 1'b1;
    low_cnt      = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (instr_valid && instr_ready) acc.push_back(cyc);
      else if (acc.size() == 1 && !instr_ready) low_cnt++;
      if (acc.size() == 2) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    check("b2b_accepts", acc.size(), 32'd2);
    gap = (acc.size() >= 2) ? acc[1] - acc[0] : 0;
    check("b2b_gap", gap, 32'd4);
    check("b2b_ready_low", low_cnt, 32'd3);
    @(negedge clk);
    wait_ready();
    check("b2b_psr", {27'b0, psr}, 32'h01);

    // Reset during EXEC of ADD r8, r9.
    instr_opcode = OpAdd;
    instr_rdest  = 4'd8;
    instr_rsrc   = 4'd9;
    instr_valid  = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_exec_op", {24'b0, alu_opcode}, {24'b0, OpAdd});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstx_we", {31'b0, rf_we}, 32'd0);
    check("rstx_done", {31'b0, done}, 32'd0);
    check("rstx_ready", {31'b0, instr_ready}, 32'd1);
    check("rstx_psr", {27'b0, psr}, 32'd0);
    repeat (3) @(negedge clk);
    check("rstx_r8", {16'b0, rf[8]}, 32'h0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
